// File: rtl/hart_control_pkg.sv
// Shared types and constants for the hart control slice (package control_pkg).
// Optional same-cycle writeback bypass is enabled with HART_CONTROL_BYPASS_EN.
package control_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    HALT  = 2'd2
  } ctrl_state_t;

  typedef enum logic [1:0] {
    NONE       = 2'd0,
    MISALIGNED = 2'd1,
    BAD_REG    = 2'd2
  } halt_cause_t;

  localparam int INSTR_BYTES = 4;
  localparam int REG_IDX_W   = 5;

  // Register indices are always carried as 5 bits; RV32E only implements the low 16.
  function automatic logic is_valid_reg(input logic [REG_IDX_W-1:0] idx, input int num_regs);
    return int'(idx) < num_regs;
  endfunction

endpackage

// File: rtl/hart_scoreboard.sv
// Per-register busy tracking: set on issue, cleared on writeback, hazard lookup per source/dest.
// With HART_CONTROL_BYPASS_EN a same-cycle writeback match is not treated as a hazard.
module hart_scoreboard
  import control_pkg::*;
#(
  parameter int NUM_REGS = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 set_en,
  input  logic [REG_IDX_W-1:0] set_idx,
  input  logic                 clr_en,
  input  logic [REG_IDX_W-1:0] clr_idx,
  input  logic [REG_IDX_W-1:0] rs1,
  input  logic [REG_IDX_W-1:0] rs2,
  input  logic [REG_IDX_W-1:0] rd,
  output logic                 hazard,
  output logic                 byp_rs1,
  output logic                 byp_rs2
);

  localparam int IDX_W = $clog2(NUM_REGS);

  logic [NUM_REGS-1:0] busy;
  logic                byp_rd;

  function automatic logic busy_at(input logic [REG_IDX_W-1:0] idx);
    return (idx != '0) && is_valid_reg(idx, NUM_REGS) && busy[idx[IDX_W-1:0]];
  endfunction

  function automatic logic wb_match(input logic [REG_IDX_W-1:0] idx);
`ifdef HART_CONTROL_BYPASS_EN
    return clr_en && (clr_idx == idx) && (idx != '0);
`else
    return 1'b0 && clr_en && (clr_idx == idx);
`endif
  endfunction

  assign byp_rs1 = wb_match(rs1);
  assign byp_rs2 = wb_match(rs2);
  assign byp_rd  = wb_match(rd);

  assign hazard = (busy_at(rs1) && !byp_rs1)
               || (busy_at(rs2) && !byp_rs2)
               || (busy_at(rd)  && !byp_rd);

  // A new issue to rd wins over a same-cycle writeback of the older value.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy <= '0;
    end else begin
      busy[0] <= 1'b0;
      for (int i = 1; i < NUM_REGS; i++) begin
        if (set_en && (set_idx == REG_IDX_W'(i))) begin
          busy[i] <= 1'b1;
        end else if (clr_en && (clr_idx == REG_IDX_W'(i))) begin
          busy[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/hart_control.sv
// Architectural state and sequencing core: regfile, PC, scoreboard, RUN/FLUSH/HALT control.
// Define HART_CONTROL_BYPASS_EN for zero-cycle writeback-to-issue forwarding.
module hart_control
  import control_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              NUM_REGS = 16,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                 clock,
  input  logic                 reset,
  output logic                 fetch_valid,
  input  logic                 fetch_ready,
  output logic [XLEN-1:0]      pc_out,
  input  logic                 issue_valid,
  output logic                 issue_ready,
  input  logic [REG_IDX_W-1:0] issue_rs1,
  input  logic [REG_IDX_W-1:0] issue_rs2,
  input  logic [REG_IDX_W-1:0] issue_rd,
  output logic [XLEN-1:0]      issue_op1,
  output logic [XLEN-1:0]      issue_op2,
  input  logic                 wb_valid,
  input  logic [REG_IDX_W-1:0] wb_rd,
  input  logic [XLEN-1:0]      wb_data,
  input  logic                 redirect_valid,
  input  logic [XLEN-1:0]      redirect_pc,
  output logic                 flush,
  output logic                 halted,
  output halt_cause_t          halt_cause,
  output ctrl_state_t          state_dbg
);

  localparam int IDX_W = $clog2(NUM_REGS);

  ctrl_state_t     state;
  logic [XLEN-1:0] regs [NUM_REGS];
  logic            idx_ok;
  logic            wb_en;
  logic            hazard;
  logic            byp_rs1;
  logic            byp_rs2;
  logic            issue_set;

  assign state_dbg = state;

  // Handshakes: a transfer happens in exactly the cycle where valid && ready are both high;
  // ready never depends on anything registered from the same transfer.
  assign idx_ok = is_valid_reg(issue_rs1, NUM_REGS)
               && is_valid_reg(issue_rs2, NUM_REGS)
               && is_valid_reg(issue_rd, NUM_REGS);

  assign wb_en = wb_valid && (wb_rd != '0) && is_valid_reg(wb_rd, NUM_REGS);

  assign issue_ready = (state == RUN) && issue_valid && idx_ok && !redirect_valid && !hazard;
  assign issue_set   = issue_ready && (issue_rd != '0);

  hart_scoreboard #(
    .NUM_REGS (NUM_REGS)
  ) u_scoreboard (
    .clock   (clock),
    .reset   (reset),
    .set_en  (issue_set),
    .set_idx (issue_rd),
    .clr_en  (wb_en),
    .clr_idx (wb_rd),
    .rs1     (issue_rs1),
    .rs2     (issue_rs2),
    .rd      (issue_rd),
    .hazard  (hazard),
    .byp_rs1 (byp_rs1),
    .byp_rs2 (byp_rs2)
  );

  function automatic logic [XLEN-1:0] read_op(input logic [REG_IDX_W-1:0] idx, input logic byp);
    if ((idx == '0) || !is_valid_reg(idx, NUM_REGS)) return '0;
    if (byp) return wb_data;
    return regs[idx[IDX_W-1:0]];
  endfunction

  assign issue_op1 = read_op(issue_rs1, byp_rs1);
  assign issue_op2 = read_op(issue_rs2, byp_rs2);

  // Writebacks retire in every state, including HALT; x0 is never written.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wb_en) begin
      regs[wb_rd[IDX_W-1:0]] <= wb_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= RUN;
      pc_out      <= RESET_PC;
      fetch_valid <= 1'b1;
      flush       <= 1'b0;
      halted      <= 1'b0;
      halt_cause  <= NONE;
    end else begin
      case (state)
        RUN: begin
          if (redirect_valid) begin
            // A redirect overrides any fetch handshake in the same cycle.
            if (redirect_pc[1:0] != 2'b00) begin
              state       <= HALT;
              fetch_valid <= 1'b0;
              halted      <= 1'b1;
              halt_cause  <= MISALIGNED;
            end else begin
              state       <= FLUSH;
              pc_out      <= redirect_pc;
              fetch_valid <= 1'b0;
              flush       <= 1'b1;
            end
          end else begin
            if (fetch_ready) begin
              pc_out <= pc_out + XLEN'(INSTR_BYTES);
            end
            if (issue_valid && !idx_ok) begin
              state       <= HALT;
              fetch_valid <= 1'b0;
              halted      <= 1'b1;
              halt_cause  <= BAD_REG;
            end
          end
        end
        FLUSH: begin
          state       <= RUN;
          fetch_valid <= 1'b1;
          flush       <= 1'b0;
        end
        HALT: begin
          state       <= HALT;
          fetch_valid <= 1'b0;
          flush       <= 1'b0;
          halted      <= 1'b1;
        end
        default: begin
          state       <= RUN;
          fetch_valid <= 1'b1;
          flush       <= 1'b0;
          halted      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hart_control.sv
// Scoreboard bench for hart_control: directed scenarios plus random traffic vs a behavioural model.
// Honours HART_CONTROL_BYPASS_EN when the build defines it.
module tb_hart_control;
  import control_pkg::*;

  localparam int          XLEN  = 32;
  localparam int          NREGS = 16;
  localparam logic [31:0] RPC   = 32'h0;
`ifdef HART_CONTROL_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clock;
  logic        reset;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] pc_out;
  logic        issue_valid;
  logic        issue_ready;
  logic [4:0]  issue_rs1;
  logic [4:0]  issue_rs2;
  logic [4:0]  issue_rd;
  logic [31:0] issue_op1;
  logic [31:0] issue_op2;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;
  logic        halted;
  halt_cause_t halt_cause;
  ctrl_state_t state_dbg;

  hart_control #(
    .XLEN     (XLEN),
    .NUM_REGS (NREGS),
    .RESET_PC (RPC)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .fetch_valid    (fetch_valid),
    .fetch_ready    (fetch_ready),
    .pc_out         (pc_out),
    .issue_valid    (issue_valid),
    .issue_ready    (issue_ready),
    .issue_rs1      (issue_rs1),
    .issue_rs2      (issue_rs2),
    .issue_rd       (issue_rd),
    .issue_op1      (issue_op1),
    .issue_op2      (issue_op2),
    .wb_valid       (wb_valid),
    .wb_rd          (wb_rd),
    .wb_data        (wb_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush          (flush),
    .halted         (halted),
    .halt_cause     (halt_cause),
    .state_dbg      (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic        fv;
    logic [31:0] pc;
    logic        ir;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        fl;
    logic        hl;
    logic [1:0]  cause;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  int          m_mode;   // 0 running, 1 flushing, 2 halted
  logic [31:0] m_pc;
  logic [1:0]  m_cause;
  logic [31:0] m_regs [32];
  bit          m_busy [32];

  task automatic model_reset();
    m_mode  = 0;
    m_pc    = RPC;
    m_cause = 2'(NONE);
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  function automatic logic m_fwd(input logic [4:0] r, input logic wv, input logic [4:0] wr);
    return BYP && wv && (wr == r) && (r != 0);
  endfunction

  function automatic logic m_haz(input logic [4:0] r, input logic wv, input logic [4:0] wr);
    return (r != 0) && (int'(r) < NREGS) && m_busy[r] && !m_fwd(r, wv, wr);
  endfunction

  function automatic logic [31:0] m_op(input logic [4:0] r, input logic wv, input logic [4:0] wr,
                                        input logic [31:0] wd);
    if (r == 0) return 32'h0;
    if (m_fwd(r, wv, wr)) return wd;
    return m_regs[r];
  endfunction

  // ---------------- driver ----------------
  task automatic idle_inputs();
    issue_valid = 0; issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0;
    wb_valid = 0; wb_rd = 0; wb_data = 0;
    redirect_valid = 0; redirect_pc = 0; fetch_ready = 0;
  endtask

  task automatic cycle(input logic iv, input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                       input logic wv, input logic [4:0] wr, input logic [31:0] wd,
                       input logic rv, input logic [31:0] rp, input logic fr);
    exp_t e;
    logic inr, acc;
    @(posedge clock);
    #1;
    issue_valid = iv; issue_rs1 = r1; issue_rs2 = r2; issue_rd = rd;
    wb_valid = wv; wb_rd = wr; wb_data = wd;
    redirect_valid = rv; redirect_pc = rp; fetch_ready = fr;

    inr = (int'(r1) < NREGS) && (int'(r2) < NREGS) && (int'(rd) < NREGS);
    acc = (m_mode == 0) && iv && inr && !rv
       && !m_haz(r1, wv, wr) && !m_haz(r2, wv, wr) && !m_haz(rd, wv, wr);
    e.fv    = (m_mode == 0);
    e.pc    = m_pc;
    e.ir    = acc;
    e.op1   = m_op(r1, wv, wr, wd);
    e.op2   = m_op(r2, wv, wr, wd);
    e.fl    = (m_mode == 1);
    e.hl    = (m_mode == 2);
    e.cause = m_cause;
    exp_q.push_back(e);

    if (wv && (wr != 0) && (int'(wr) < NREGS)) begin
      m_regs[wr] = wd;
      m_busy[wr] = 1'b0;
    end
    if (acc && (rd != 0)) m_busy[rd] = 1'b1;
    case (m_mode)
      0: begin
        if (rv) begin
          if (rp[1:0] != 2'b00) begin
            m_mode = 2; m_cause = 2'(MISALIGNED);
          end else begin
            m_pc = rp; m_mode = 1;
          end
        end else begin
          if (fr) m_pc = m_pc + 32'd4;
          if (iv && !inr) begin
            m_mode = 2; m_cause = 2'(BAD_REG);
          end
        end
      end
      1: m_mode = 0;
      default: ;
    endcase
  endtask

  task automatic issue_c(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd);
    cycle(1, r1, r2, rd, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic nop_c(input logic fr);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, fr);
  endtask

  // Reset asserted asynchronously between edges; reset values checked while held.
  task automatic do_reset();
    @(posedge clock);
    #2;
    reset = 1'b0;
    idle_inputs();
    model_reset();
    @(negedge clock);
    check("rst_fetch_valid", 32'(fetch_valid), 32'd1);
    check("rst_pc_out", pc_out, RPC);
    check("rst_issue_ready", 32'(issue_ready), 32'd0);
    check("rst_op1", issue_op1, 32'd0);
    check("rst_op2", issue_op2, 32'd0);
    check("rst_flush", 32'(flush), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_cause", 32'(halt_cause), 32'(NONE));
    @(negedge clock);
    reset = 1'b1;
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("fetch_valid", 32'(fetch_valid), 32'(e.fv));
        check("pc_out", pc_out, e.pc);
        check("issue_ready", 32'(issue_ready), 32'(e.ir));
        check("flush", 32'(flush), 32'(e.fl));
        check("halted", 32'(halted), 32'(e.hl));
        check("halt_cause", 32'(halt_cause), 32'(e.cause));
        if (e.ir) begin
          check("issue_op1", issue_op1, e.op1);
          check("issue_op2", issue_op2, e.op2);
        end
      end
    end
  end

  initial begin
    #2000000;
    n_checks++;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [4:0]  r1, r2, rd, wr;
    logic        iv, wv, rv, fr;
    logic [31:0] wd, rp;

    reset = 1'b0;
    idle_inputs();
    model_reset();
    @(negedge clock);
    check("init_fetch_valid", 32'(fetch_valid), 32'd1);
    check("init_pc_out", pc_out, RPC);
    check("init_halted", 32'(halted), 32'd0);
    @(negedge clock);
    reset = 1'b1;

    // Reset then three fetch handshakes.
    nop_c(1); nop_c(1); nop_c(1);
    nop_c(0);
    #2 check("fetch3_pc", pc_out, 32'hC);

    // RAW hazard and writeback release.
    issue_c(1, 2, 5);
    #2 check("raw_first_accept", 32'(issue_ready), 32'd1);
    issue_c(5, 0, 6);
    #2 check("raw_stall", 32'(issue_ready), 32'd0);
    cycle(1, 5, 0, 6, 1, 5, 32'h1234, 0, 0, 0);
    #2 check("raw_wb_same_cycle", 32'(issue_ready), 32'(BYP));
    check("raw_wb_same_op1", issue_op1, BYP ? 32'h1234 : 32'h0);
    issue_c(5, 0, 7);
    #2 check("raw_next_accept", 32'(issue_ready), 32'd1);
    check("raw_next_op1", issue_op1, 32'h1234);
    cycle(0, 0, 0, 0, 1, 6, 32'h66, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 7, 32'h77, 0, 0, 0);

    // Redirect beats fetch, then one flush cycle, then misaligned redirect.
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 32'h100, 1);
    nop_c(1);
    #2 check("redir_flush", 32'(flush), 32'd1);
    check("redir_pc", pc_out, 32'h100);
    check("redir_fetch_valid", 32'(fetch_valid), 32'd0);
    nop_c(0);
    #2 check("redir_flush_done", 32'(flush), 32'd0);
    check("redir_pc_held", pc_out, 32'h100);
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 32'h102, 1);
    nop_c(0);
    #2 check("misaligned_halted", 32'(halted), 32'd1);
    check("misaligned_cause", 32'(halt_cause), 32'(MISALIGNED));
    check("misaligned_pc", pc_out, 32'h100);
    cycle(1, 1, 0, 0, 1, 9, 32'h99, 0, 0, 1);
    #2 check("halt_no_issue", 32'(issue_ready), 32'd0);
    do_reset();

    // Out-of-range register index on RV32E.
    issue_c(1, 17, 2);
    #2 check("badreg_not_ready", 32'(issue_ready), 32'd0);
    nop_c(0);
    #2 check("badreg_halted", 32'(halted), 32'd1);
    check("badreg_cause", 32'(halt_cause), 32'(BAD_REG));
    do_reset();

    // x0 is never written and never busy.
    cycle(0, 0, 0, 0, 1, 0, 32'hFFFF, 0, 0, 0);
    issue_c(0, 0, 0);
    #2 check("x0_op1", issue_op1, 32'h0);
    check("x0_accept", 32'(issue_ready), 32'd1);
    issue_c(0, 0, 0);
    #2 check("x0_rd_no_stall", 32'(issue_ready), 32'd1);

    // Reset mid-operation clears pending busy bits and register contents.
    cycle(0, 0, 0, 0, 1, 3, 32'hABCD, 0, 0, 0);
    issue_c(0, 0, 3);
    do_reset();
    issue_c(3, 0, 3);
    #2 check("post_reset_accept", 32'(issue_ready), 32'd1);
    check("post_reset_op1", issue_op1, 32'h0);

    // Random traffic in blocks separated by resets.
    for (int blk = 0; blk < 25; blk++) begin
      for (int c = 0; c < 40; c++) begin
        iv = 1'($urandom_range(0, 1));
        r1 = ($urandom_range(0, 99) < 2) ? 5'($urandom_range(16, 31)) : 5'($urandom_range(0, 7));
        r2 = 5'($urandom_range(0, 7));
        rd = 5'($urandom_range(0, 7));
        wv = 1'($urandom_range(0, 1));
        wr = ($urandom_range(0, 99) < 5) ? 5'($urandom_range(16, 31)) : 5'($urandom_range(0, 7));
        wd = $urandom;
        rv = ($urandom_range(0, 99) < 4);
        rp = $urandom;
        if ($urandom_range(0, 3) != 0) rp[1:0] = 2'b00;
        fr = 1'($urandom_range(0, 1));
        cycle(iv, r1, r2, rd, wv, wr, wd, rv, rp, fr);
      end
      do_reset();
    end

    nop_c(0);
    @(negedge clock);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
